// File: rtl/qspi_io_phy_if.sv
// Controller-side bundle of the QSPI pad stage: strobes, mode/direction
// controls, write data and the captured read data.
interface qspi_io_phy_if #(
  parameter int IO_WIDTH = 8,
  parameter int TA_W     = 3
);
  logic                drive_edge;
  logic                sample_edge;
  logic [1:0]          mode;
  logic                dir;
  logic [TA_W-1:0]     ta_cycles;
  logic [1:0]          sample_dly;
  logic [IO_WIDTH-1:0] idle_level;
  logic [IO_WIDTH-1:0] idle_oe;
  logic [IO_WIDTH-1:0] data_out;
  logic [IO_WIDTH-1:0] data_in;
  logic                data_valid;
  logic                cur_dir;
  logic                ta_busy;

  modport master (
    output drive_edge, sample_edge, mode, dir, ta_cycles, sample_dly,
           idle_level, idle_oe, data_out,
    input  data_in, data_valid, cur_dir, ta_busy
  );

  modport slave (
    input  drive_edge, sample_edge, mode, dir, ta_cycles, sample_dly,
           idle_level, idle_oe, data_out,
    output data_in, data_valid, cur_dir, ta_busy
  );
endinterface

// File: rtl/qspi_io_phy.sv
// QSPI pad stage: lane-width masking, hi-Z turnaround between write and
// read, static idle-lane drive and delayed read capture.
module qspi_io_phy #(
  parameter int IO_WIDTH = 8,
  parameter int TA_W     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  qspi_io_phy_if.slave        bus,
  inout  wire  [IO_WIDTH-1:0] io
);

  if (IO_WIDTH != 4 && IO_WIDTH != 8) begin : g_width_check
    $error("qspi_io_phy: IO_WIDTH must be 4 or 8");
  end

  typedef enum logic [1:0] {
    ST_WR,
    ST_RD,
    ST_TA
  } state_t;

  state_t              state;
  logic [TA_W-1:0]     cnt;
  logic [IO_WIDTH-1:0] mask;
  logic [IO_WIDTH-1:0] data_oe;
  logic [IO_WIDTH-1:0] data_q;
  logic [IO_WIDTH-1:0] idle_oe_q;
  logic [IO_WIDTH-1:0] idle_q;
  logic [IO_WIDTH-1:0] pad_oe;
  logic [IO_WIDTH-1:0] pad_out;
  logic [1:0]          rd_dly;
  logic [2:0]          dly_line;
  logic [3:0]          taps;
  logic                cap;
  logic [IO_WIDTH-1:0] cap_val;
  logic [IO_WIDTH-1:0] data_in_q;
  logic                data_valid_q;

  always_comb begin
    mask = '0;
    unique case (bus.mode)
      2'b00: mask[0]   = 1'b1;
      2'b01: mask[1:0] = '1;
      2'b10: mask[3:0] = '1;
      2'b11: if (IO_WIDTH == 8) mask = '1;
      default: mask = '0;
    endcase
  end

  // FSM, masked-lane drive and idle-lane drive all advance on drive_edge only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RD;
      cnt       <= '0;
      data_oe   <= '0;
      data_q    <= '0;
      idle_oe_q <= '0;
      idle_q    <= '0;
      rd_dly    <= '0;
    end else if (bus.drive_edge) begin
      idle_oe_q <= bus.idle_oe & ~mask;
      idle_q    <= bus.idle_level & ~mask;
      unique case (state)
        ST_WR: begin
          if (!bus.dir) begin
            data_q  <= bus.data_out & mask;
            data_oe <= mask;
          end else begin
            data_oe <= '0;
            if (bus.ta_cycles == '0) begin
              state  <= ST_RD;
              rd_dly <= bus.sample_dly;
            end else begin
              state <= ST_TA;
              cnt   <= bus.ta_cycles;
            end
          end
        end
        ST_RD: begin
          data_oe <= '0;
          if (!bus.dir) begin
            if (bus.ta_cycles == '0) begin
              state   <= ST_WR;
              data_q  <= bus.data_out & mask;
              data_oe <= mask;
            end else begin
              state <= ST_TA;
              cnt   <= bus.ta_cycles;
            end
          end
        end
        ST_TA: begin
          data_oe <= '0;
          cnt     <= cnt - TA_W'(1);
          // Exit target follows dir at the final edge; earlier toggles are ignored.
          if (cnt == TA_W'(1)) begin
            if (bus.dir) begin
              state  <= ST_RD;
              rd_dly <= bus.sample_dly;
            end else begin
              state   <= ST_WR;
              data_q  <= bus.data_out & mask;
              data_oe <= mask;
            end
          end
        end
        default: begin
          state   <= ST_RD;
          data_oe <= '0;
        end
      endcase
    end
  end

  assign pad_oe  = data_oe | idle_oe_q;
  assign pad_out = (data_oe & data_q) | (~data_oe & idle_q);

  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_pad
    assign io[i] = pad_oe[i] ? pad_out[i] : 1'bz;
  end

  assign taps = {dly_line, bus.sample_edge};
  assign cap  = taps[rd_dly];

  always_comb begin
    cap_val = '0;
    if (bus.mode == 2'b00) cap_val[0] = io[1];
    else                   cap_val    = io & mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_line     <= '0;
      data_in_q    <= '0;
      data_valid_q <= 1'b0;
    end else begin
      dly_line     <= {dly_line[1:0], bus.sample_edge};
      data_valid_q <= 1'b0;
      if (cap && state == ST_RD) begin
        data_in_q    <= cap_val;
        data_valid_q <= 1'b1;
      end
    end
  end

  assign bus.data_in    = data_in_q;
  assign bus.data_valid = data_valid_q;
  assign bus.cur_dir    = (state == ST_RD);
  assign bus.ta_busy    = (state == ST_TA);

endmodule

// File: doc/qspi_io_phy.md
# qspi_io_phy

Parametrised bidirectional I/O stage for the QSPI controller, sitting between the shift register and the pads. It supports single, dual, quad and octal lane widths. It enforces a programmable hi-Z turnaround gap on every bus direction change and registers read data at a programmable delay after the sample strobe. Lanes not used by the current mode can be held at a static level, for example WP#/HOLD# high in single/dual mode.

## Interface
- `IO_WIDTH`, 8: physical lane count; must be 4 or 8.
- `TA_W`, 3: width of the turnaround counter and of `ta_cycles`.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `drive_edge` in 1: one-cycle strobe from the clock generator; launches drive data and advances the FSM.
- `sample_edge` in 1: one-cycle strobe from the clock generator; nominal read-sample point.
- `mode` in 2: 00 single, 01 dual, 10 quad, 11 octal.
- `dir` in 1: requested direction; 0 write, 1 read.
- `ta_cycles` in TA_W: hi-Z gap on a direction change, in drive_edge periods; 0 means no gap.
- `sample_dly` in 2: extra clk delay, 0..3, from sample_edge to capture.
- `idle_level` in IO_WIDTH: level driven on lanes outside the mode mask.
- `idle_oe` in IO_WIDTH: per-lane enable for the idle drive.
- `data_out` in IO_WIDTH: write data, right-aligned.
- `io` inout IO_WIDTH: pad lines.
- `data_in` out IO_WIDTH: captured read data, right-aligned.
- `data_valid` out 1: one-cycle pulse when `data_in` updates.
- `cur_dir` out 1: 1 while in RD, otherwise 0.
- `ta_busy` out 1: high while in TA.

## Operation
- Mode mask: single = lane 0, dual = lanes 1:0, quad = 3:0, octal = 7:0.
  - Octal with `IO_WIDTH`=4 gives an empty mask: nothing is driven and nothing is captured.
- FSM states: WR, RD, TA. Reset state is RD with all lanes released.
- Transitions are evaluated only on `drive_edge` cycles.
- WR with `dir`=0: `io_out <= data_out & mask`; `oe <= mask`.
- WR with `dir`=1:
  - If `ta_cycles`=0: go to RD; clear `oe` for masked lanes.
  - Otherwise: go to TA; clear `oe`; `cnt <= ta_cycles`.
- RD with `dir`=0: symmetric to WR with `dir`=1. With `ta_cycles`=0, go to WR and drive `data_out` on the same edge.
- RD with `dir`=1: stay in RD; masked lanes remain released.
- TA: masked lanes are released.
  - Each `drive_edge` decrements `cnt`.
  - On the edge where `cnt`=1, the target is taken from the current `dir`. If the target is WR, `data_out` is driven on that same edge.
  - A `dir` toggle during TA does not restart or abort the gap.
  - The gap is exactly `ta_cycles` drive periods.
- Idle lanes (outside the mask): driven with `idle_level[i]` when `idle_oe[i]`=1, otherwise hi-Z. This applies in every state, TA included.
  - Idle-lane drive updates on `drive_edge` only.
- Capture path:
  - `sample_edge` feeds a 3-stage delay line; tap `sample_dly` selects the capture pulse (tap 0 is undelayed).
  - `sample_dly` is registered on entry to RD and held for the whole RD stay.
  - A capture pulse that lands while the state is RD updates `data_in` and pulses `data_valid`. Pulses landing in WR or TA are discarded with no `data_valid`.
  - Capture mapping (unmasked `data_in` bits are 0):
    - single: `data_in[0] = io[1]` (MISO).
    - dual/quad/octal: `data_in[k] = io[k]` for masked k.
- `mode` and `dir` are used as sampled at the relevant edge. Changing `mode` in WR takes effect at the next `drive_edge`.
- Reset, asynchronous at any time, including mid-TA or mid-drive:
  - All `oe` = 0; `io_out` = 0; state = RD; `cnt` = 0; delay line cleared.
  - Outputs: `data_in` = 0, `data_valid` = 0, `cur_dir` = 1, `ta_busy` = 0.
  - Idle lanes are hi-Z until the first `drive_edge` after release.

## Timing
- Drive latency: a `drive_edge` in cycle t updates `io` from cycle t+1.
- `cur_dir` and `ta_busy` change in cycle t+1 after the deciding `drive_edge`.
- Capture latency: `sample_edge` in cycle t with `sample_dly`=d samples `io` at the end of cycle t+d. `data_in`/`data_valid` are visible in cycle t+d+1.
- `data_valid` stays high for exactly 1 cycle per capture.
- Back-to-back captures are possible every cycle.
- If `drive_edge` and a capture pulse coincide on an RD→WR edge, the capture still completes, since the state was RD at that edge.
- Lane release on entry to TA occurs in the same cycle as the last write data would have been driven. There is never an overlap of drive and release.

## Test plan
- Quad write: `mode`=10, `dir`=0, `data_out`=8'hA5 on `drive_edge` → `io`=zzzz_0101 next cycle. With `idle_oe`=8'h00, lanes 7:4 stay hi-Z.
- Single read with idle hold: `mode`=00, `dir`=1, `idle_oe`=8'h0C, `idle_level`=8'h0C, `io[1]`=1, `sample_edge`, `sample_dly`=2 → lanes 3:2 driven 1. `data_in`=8'h01 and `data_valid` pulse 3 cycles after the strobe.
- Turnaround: WR→RD with `ta_cycles`=3 → `ta_busy` high for exactly 3 drive periods with masked lanes hi-Z. `sample_edge` during TA gives no `data_valid`. `cur_dir`=1 afterward.
- Direction flip mid-TA: `ta_cycles`=2, `dir` 0→1, then `dir` back to 0 after one edge → gap still 2 periods. Then WR, driving `data_out` on the final edge.
- Zero turnaround plus octal: `mode`=11, `ta_cycles`=0, RD→WR → `data_out`=8'h3C appears on all 8 lanes one cycle after that `drive_edge`. `ta_busy` never asserts.
- Reset mid-write: `reset_n` low while driving 8'hFF → all lanes hi-Z within the same cycle. `cur_dir`=1, `data_in`=0, and no drive until `dir`=0 plus `drive_edge`.
